// File: rtl/vscale_hasti_arbiter.sv
// Two-master, one-slave AHB-lite arbiter: dmem bridge (m0) and imem bridge (m1) share one slave.
// Grants address phases, tracks data-phase ownership and holds one completed response per master.
module vscale_hasti_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int HASTI_W  = 32
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [HASTI_W-1:0] m0_haddr,
    input  logic               m0_hwrite,
    input  logic [2:0]         m0_hsize,
    input  logic [2:0]         m0_hburst,
    input  logic               m0_hmastlock,
    input  logic [3:0]         m0_hprot,
    input  logic [1:0]         m0_htrans,
    input  logic [HASTI_W-1:0] m0_hwdata,
    output logic [HASTI_W-1:0] m0_hrdata,
    output logic               m0_hready,
    output logic               m0_hresp,
    input  logic [HASTI_W-1:0] m1_haddr,
    input  logic               m1_hwrite,
    input  logic [2:0]         m1_hsize,
    input  logic [2:0]         m1_hburst,
    input  logic               m1_hmastlock,
    input  logic [3:0]         m1_hprot,
    input  logic [1:0]         m1_htrans,
    input  logic [HASTI_W-1:0] m1_hwdata,
    output logic [HASTI_W-1:0] m1_hrdata,
    output logic               m1_hready,
    output logic               m1_hresp,
    output logic [HASTI_W-1:0] s_haddr,
    output logic               s_hwrite,
    output logic [2:0]         s_hsize,
    output logic [2:0]         s_hburst,
    output logic               s_hmastlock,
    output logic [3:0]         s_hprot,
    output logic [1:0]         s_htrans,
    output logic [HASTI_W-1:0] s_hwdata,
    input  logic [HASTI_W-1:0] s_hrdata,
    input  logic               s_hready,
    input  logic               s_hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {
        DP_NONE = 2'd0,
        DP_M0   = 2'd1,
        DP_M1   = 2'd2
    } dp_owner_e;

    dp_owner_e          dp_owner_q, dp_owner_d;
    logic               last_grant_q, last_grant_d;   // 1 = m1 was granted last
    logic               buf_valid0_q, buf_valid0_d, buf_valid1_q, buf_valid1_d;
    logic [HASTI_W-1:0] buf_data0_q, buf_data0_d, buf_data1_q, buf_data1_d;
    logic               buf_resp0_q, buf_resp0_d, buf_resp1_q, buf_resp1_d;

    logic req0, req1;
    logic gnt_valid, gnt_m1, sel_m1;
    logic data_done0, data_done1, addr_done0, addr_done1;

    assign req0 = m0_htrans[1];
    assign req1 = m1_htrans[1];

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_m1    = 1'b0;
        if (hresetn && s_hready) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
                if (last_grant_q && m1_hmastlock)       gnt_m1 = 1'b1;
                else if (!last_grant_q && m0_hmastlock) gnt_m1 = 1'b0;
                else if (ARB_MODE == 1)                 gnt_m1 = 1'b0;
                else                                    gnt_m1 = !last_grant_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_m1    = 1'b1;
            end
        end
    end

    // Address-phase signals follow m0 whenever nobody is granted.
    assign sel_m1      = gnt_valid && gnt_m1;
    assign s_haddr     = sel_m1 ? m1_haddr     : m0_haddr;
    assign s_hwrite    = sel_m1 ? m1_hwrite    : m0_hwrite;
    assign s_hsize     = sel_m1 ? m1_hsize     : m0_hsize;
    assign s_hburst    = sel_m1 ? m1_hburst    : m0_hburst;
    assign s_hmastlock = sel_m1 ? m1_hmastlock : m0_hmastlock;
    assign s_hprot     = sel_m1 ? m1_hprot     : m0_hprot;
    assign s_htrans    = !gnt_valid ? HTRANS_IDLE : (sel_m1 ? m1_htrans : m0_htrans);
    assign s_hwdata    = (dp_owner_q == DP_M1) ? m1_hwdata : m0_hwdata;

    assign data_done0 = (dp_owner_q != DP_M0) || buf_valid0_q || s_hready;
    assign data_done1 = (dp_owner_q != DP_M1) || buf_valid1_q || s_hready;
    assign addr_done0 = !req0 || (gnt_valid && !gnt_m1);
    assign addr_done1 = !req1 || (gnt_valid && gnt_m1);

    assign m0_hready = !hresetn || (data_done0 && addr_done0);
    assign m1_hready = !hresetn || (data_done1 && addr_done1);
    assign m0_hrdata = buf_valid0_q ? buf_data0_q : s_hrdata;
    assign m0_hresp  = buf_valid0_q ? buf_resp0_q : s_hresp;
    assign m1_hrdata = buf_valid1_q ? buf_data1_q : s_hrdata;
    assign m1_hresp  = buf_valid1_q ? buf_resp1_q : s_hresp;

    always_comb begin
        dp_owner_d   = dp_owner_q;
        last_grant_d = last_grant_q;
        buf_valid0_d = buf_valid0_q;
        buf_valid1_d = buf_valid1_q;
        buf_data0_d  = buf_data0_q;
        buf_data1_d  = buf_data1_q;
        buf_resp0_d  = buf_resp0_q;
        buf_resp1_d  = buf_resp1_q;

        if (s_hready) begin
            dp_owner_d = !gnt_valid ? DP_NONE : (gnt_m1 ? DP_M1 : DP_M0);
            if (gnt_valid) last_grant_d = gnt_m1;
        end

        // A finished data phase whose owner's next address lost arbitration is parked here.
        if (m0_hready) begin
            buf_valid0_d = 1'b0;
        end else if (dp_owner_q == DP_M0 && s_hready && !addr_done0) begin
            buf_valid0_d = 1'b1;
            buf_data0_d  = s_hrdata;
            buf_resp0_d  = s_hresp;
        end

        if (m1_hready) begin
            buf_valid1_d = 1'b0;
        end else if (dp_owner_q == DP_M1 && s_hready && !addr_done1) begin
            buf_valid1_d = 1'b1;
            buf_data1_d  = s_hrdata;
            buf_resp1_d  = s_hresp;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            dp_owner_q   <= DP_NONE;
            last_grant_q <= 1'b1;
            buf_valid0_q <= 1'b0;
            buf_valid1_q <= 1'b0;
        end else begin
            dp_owner_q   <= dp_owner_d;
            last_grant_q <= last_grant_d;
            buf_valid0_q <= buf_valid0_d;
            buf_valid1_q <= buf_valid1_d;
        end
    end

    // NOTE: buffer payload has no reset; it is only ever observed while its valid flag is set.
    always_ff @(posedge hclk) begin
        buf_data0_q <= buf_data0_d;
        buf_data1_q <= buf_data1_d;
        buf_resp0_q <= buf_resp0_d;
        buf_resp1_q <= buf_resp1_d;
    end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: cycle vector table plus read-data scoreboard,
// with a round-robin instance (dut_rr) and a fixed-priority instance (dut_fp) on shared inputs.
module tb_vscale_hasti_arbiter;

    localparam int W  = 32;
    localparam int GN = 0;   // no grant
    localparam int G0 = 1;   // master 0 granted
    localparam int G1 = 2;   // master 1 granted
    localparam int SK = -1;  // not checked
    localparam logic [W-1:0] WD0 = 32'hDEADBEEF;
    localparam logic [W-1:0] WD1 = 32'h11111111;

    typedef struct {
        logic         rst_n;
        logic         rdy;
        logic         r0;
        logic         w0;
        logic [W-1:0] a0;
        logic         r1;
        logic [W-1:0] a1;
        logic         lk1;
        int           g0;    // expected grant, round-robin instance
        logic         h0;
        logic         h1;
        int           wd;    // 0 none, 1 expect m0 wdata, 2 expect m1 wdata
        int           g1;    // expected grant, fixed-priority instance
        logic         h1b;   // expected m1_hready, fixed-priority instance
        logic [W-1:0] r1x;   // expected m1_hrdata when nonzero
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    logic         hclk = 1'b0;
    logic         hresetn = 1'b0;
    logic [W-1:0] m0_haddr = '0, m1_haddr = '0;
    logic         m0_hwrite = 1'b0, m1_hwrite = 1'b0;
    logic [2:0]   hsize = 3'b010, hburst = 3'b000;
    logic [3:0]   hprot = 4'b0011;
    logic         m0_hmastlock = 1'b0, m1_hmastlock = 1'b0;
    logic [1:0]   m0_htrans = 2'b00, m1_htrans = 2'b00;
    logic         s_hready = 1'b1;
    logic [W-1:0] s_hrdata;
    logic         s_hresp;

    logic [W-1:0] a_m0_hrdata, a_m1_hrdata, a_s_haddr, a_s_hwdata;
    logic         a_m0_hready, a_m1_hready, a_m0_hresp, a_m1_hresp;
    logic         a_s_hwrite, a_s_hmastlock;
    logic [2:0]   a_s_hsize, a_s_hburst;
    logic [3:0]   a_s_hprot;
    logic [1:0]   a_s_htrans;

    logic [W-1:0] b_m0_hrdata, b_m1_hrdata, b_s_haddr, b_s_hwdata;
    logic         b_m0_hready, b_m1_hready, b_m0_hresp, b_m1_hresp;
    logic         b_s_hwrite, b_s_hmastlock;
    logic [2:0]   b_s_hsize, b_s_hburst;
    logic [3:0]   b_s_hprot;
    logic [1:0]   b_s_htrans;

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 hclk = ~hclk;

    // Zero-wait slave model returning address + 0x100, driven by the round-robin instance.
    logic [W-1:0] slv_addr_q = '0;
    always @(posedge hclk) if (s_hready && a_s_htrans[1]) slv_addr_q <= a_s_haddr;
    assign s_hrdata = slv_addr_q + 32'h100;
    assign s_hresp  = 1'b0;

    vscale_hasti_arbiter #(.ARB_MODE(0), .HASTI_W(W)) dut_rr (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(hsize), .m0_hburst(hburst),
        .m0_hmastlock(m0_hmastlock), .m0_hprot(hprot), .m0_htrans(m0_htrans), .m0_hwdata(WD0),
        .m0_hrdata(a_m0_hrdata), .m0_hready(a_m0_hready), .m0_hresp(a_m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(hsize), .m1_hburst(hburst),
        .m1_hmastlock(m1_hmastlock), .m1_hprot(hprot), .m1_htrans(m1_htrans), .m1_hwdata(WD1),
        .m1_hrdata(a_m1_hrdata), .m1_hready(a_m1_hready), .m1_hresp(a_m1_hresp),
        .s_haddr(a_s_haddr), .s_hwrite(a_s_hwrite), .s_hsize(a_s_hsize), .s_hburst(a_s_hburst),
        .s_hmastlock(a_s_hmastlock), .s_hprot(a_s_hprot), .s_htrans(a_s_htrans),
        .s_hwdata(a_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    vscale_hasti_arbiter #(.ARB_MODE(1), .HASTI_W(W)) dut_fp (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(hsize), .m0_hburst(hburst),
        .m0_hmastlock(m0_hmastlock), .m0_hprot(hprot), .m0_htrans(m0_htrans), .m0_hwdata(WD0),
        .m0_hrdata(b_m0_hrdata), .m0_hready(b_m0_hready), .m0_hresp(b_m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(hsize), .m1_hburst(hburst),
        .m1_hmastlock(m1_hmastlock), .m1_hprot(hprot), .m1_htrans(m1_htrans), .m1_hwdata(WD1),
        .m1_hrdata(b_m1_hrdata), .m1_hready(b_m1_hready), .m1_hresp(b_m1_hresp),
        .s_haddr(b_s_haddr), .s_hwrite(b_s_hwrite), .s_hsize(b_s_hsize), .s_hburst(b_s_hburst),
        .s_hmastlock(b_s_hmastlock), .s_hprot(b_s_hprot), .s_htrans(b_s_htrans),
        .s_hwdata(b_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        hresetn      = v.rst_n;
        s_hready     = v.rdy;
        m0_htrans    = v.r0 ? 2'b10 : 2'b00;
        m0_hwrite    = v.w0;
        m0_haddr     = v.a0;
        m1_htrans    = v.r1 ? 2'b10 : 2'b00;
        m1_haddr     = v.a1;
        m1_hmastlock = v.lk1;
    endtask

    initial begin
        //            rst rdy r0 w0 a0     r1 a1     lk  g0  h0 h1 wd  g1  h1b r1x
        vecs[0]  = '{0, 1, 1, 0, 'h00, 1, 'h00, 0, GN, 1, 1, 0, GN, 1, 'h0};
        vecs[1]  = '{1, 1, 0, 0, 'h00, 1, 'h00, 0, G1, 1, 1, 0, G1, 1, 'h0};
        vecs[2]  = '{1, 1, 0, 0, 'h00, 1, 'h04, 0, G1, 1, 1, 0, SK, 0, 'h0};
        vecs[3]  = '{1, 1, 0, 0, 'h00, 1, 'h08, 0, G1, 1, 1, 0, SK, 0, 'h0};
        vecs[4]  = '{1, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, SK, 0, 'h0};
        vecs[5]  = '{0, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, GN, 1, 'h0};
        vecs[6]  = '{1, 1, 1, 0, 'h40, 1, 'h10, 0, G0, 1, 0, 0, G0, 0, 'h0};
        vecs[7]  = '{1, 1, 1, 0, 'h44, 1, 'h10, 0, G1, 0, 1, 0, G0, 0, 'h0};
        vecs[8]  = '{1, 1, 1, 0, 'h44, 1, 'h14, 0, G0, 1, 0, 0, G0, 0, 'h0};
        vecs[9]  = '{1, 1, 1, 0, 'h48, 1, 'h14, 0, G1, 0, 1, 0, G0, 0, 'h0};
        vecs[10] = '{1, 1, 1, 0, 'h48, 0, 'h00, 0, G0, 1, 1, 0, G0, 1, 'h0};
        vecs[11] = '{1, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, GN, 1, 'h0};
        vecs[12] = '{1, 1, 0, 0, 'h00, 1, 'h60, 1, G1, 1, 1, 0, G1, 1, 'h0};
        vecs[13] = '{1, 1, 1, 0, 'h70, 1, 'h64, 1, G1, 0, 1, 0, G1, 1, 'h0};
        vecs[14] = '{1, 1, 1, 0, 'h70, 0, 'h00, 0, G0, 1, 1, 0, G0, 1, 'h0};
        vecs[15] = '{1, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, GN, 1, 'h0};
        vecs[16] = '{0, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, GN, 1, 'h0};
        vecs[17] = '{1, 1, 1, 0, 'hA0, 1, 'hA4, 0, G0, 1, 0, 0, G0, 0, 'h0};
        vecs[18] = '{1, 1, 0, 0, 'h00, 1, 'hA4, 0, G1, 1, 1, 0, SK, 0, 'h0};
        vecs[19] = '{1, 1, 1, 1, 'h20, 0, 'h00, 0, G0, 1, 1, 2, SK, 0, 'h0};
        vecs[20] = '{1, 0, 0, 0, 'h00, 1, 'h30, 0, GN, 0, 0, 1, SK, 0, 'h0};
        vecs[21] = '{1, 0, 0, 0, 'h00, 1, 'h30, 0, GN, 0, 0, 1, SK, 0, 'h0};
        vecs[22] = '{1, 0, 0, 0, 'h00, 1, 'h30, 0, GN, 0, 0, 1, SK, 0, 'h0};
        vecs[23] = '{1, 1, 0, 0, 'h00, 1, 'h30, 0, G1, 1, 1, 1, SK, 0, 'h0};
        vecs[24] = '{1, 1, 1, 0, 'h90, 1, 'h80, 0, G0, 1, 0, 0, SK, 0, 'h0};
        vecs[25] = '{0, 1, 1, 0, 'h94, 1, 'h80, 0, GN, 1, 1, 0, SK, 0, 'h0};
        vecs[26] = '{1, 1, 1, 0, 'h94, 1, 'h80, 0, G0, 1, 0, 0, SK, 0, 'h190};
        vecs[27] = '{1, 1, 0, 0, 'h00, 1, 'h80, 0, G1, 1, 1, 0, SK, 0, 'h0};
        vecs[28] = '{1, 1, 0, 0, 'h00, 0, 'h00, 0, GN, 1, 1, 0, SK, 0, 'h0};

        #1;
        for (int i = 0; i < NV; i++) begin
            vec_t v;
            v = vecs[i];
            drive(v);
            @(negedge hclk);
            check($sformatf("v%0d s_htrans", i), 32'(a_s_htrans), (v.g0 != GN) ? 32'h2 : 32'h0);
            check($sformatf("v%0d s_haddr", i), a_s_haddr, (v.g0 == G1) ? v.a1 : v.a0);
            check($sformatf("v%0d m0_hready", i), 32'(a_m0_hready), 32'(v.h0));
            check($sformatf("v%0d m1_hready", i), 32'(a_m1_hready), 32'(v.h1));
            if (v.wd == 1) check($sformatf("v%0d s_hwdata", i), a_s_hwdata, WD0);
            if (v.wd == 2) check($sformatf("v%0d s_hwdata", i), a_s_hwdata, WD1);
            if (v.g1 != SK) begin
                check($sformatf("v%0d fp s_htrans", i), 32'(b_s_htrans), (v.g1 != GN) ? 32'h2 : 32'h0);
                check($sformatf("v%0d fp s_haddr", i), b_s_haddr, (v.g1 == G1) ? v.a1 : v.a0);
                check($sformatf("v%0d fp m1_hready", i), 32'(b_m1_hready), 32'(v.h1b));
            end
            if (v.r1x != 0) check($sformatf("v%0d m1_hrdata", i), a_m1_hrdata, v.r1x);

            // Scoreboard: read data expected when a granted read's data phase completes.
            if (!v.rst_n) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && a_m0_hready) check($sformatf("v%0d m0_hrdata", i), a_m0_hrdata, q0.pop_front());
                if (q1.size() != 0 && a_m1_hready) check($sformatf("v%0d m1_hrdata", i), a_m1_hrdata, q1.pop_front());
                if (v.g0 == G0 && !v.w0) q0.push_back(v.a0 + 32'h100);
                if (v.g0 == G1) q1.push_back(v.a1 + 32'h100);
            end
            @(posedge hclk);
            #1;
        end
        check("sb q0 drained", 32'(q0.size()), 32'h0);
        check("sb q1 drained", 32'(q1.size()), 32'h0);

        // Hand sequence: m1 response parked in its buffer survives a slave stall.
        drive('{1, 1, 0, 0, 'h00, 1, 'hC0, 0, SK, 0, 0, 0, SK, 0, 'h0});
        @(negedge hclk);
        check("h1 s_haddr", a_s_haddr, 32'hC0);
        @(posedge hclk); #1;

        drive('{1, 1, 1, 0, 'hB0, 1, 'hC4, 0, SK, 0, 0, 0, SK, 0, 'h0});
        @(negedge hclk);
        check("h2 s_haddr", a_s_haddr, 32'hB0);
        check("h2 m1_hready", 32'(a_m1_hready), 32'h0);
        @(posedge hclk); #1;

        drive('{1, 0, 0, 0, 'h00, 1, 'hC4, 0, SK, 0, 0, 0, SK, 0, 'h0});
        @(negedge hclk);
        check("h3 s_htrans", 32'(a_s_htrans), 32'h0);
        check("h3 m0_hready", 32'(a_m0_hready), 32'h0);
        check("h3 m1_hready", 32'(a_m1_hready), 32'h0);
        check("h3 m1_hrdata", a_m1_hrdata, 32'h1C0);
        @(posedge hclk); #1;

        drive('{1, 1, 0, 0, 'h00, 1, 'hC4, 0, SK, 0, 0, 0, SK, 0, 'h0});
        @(negedge hclk);
        check("h4 s_htrans", 32'(a_s_htrans), 32'h2);
        check("h4 s_haddr", a_s_haddr, 32'hC4);
        check("h4 m1_hready", 32'(a_m1_hready), 32'h1);
        check("h4 m1_hrdata", a_m1_hrdata, 32'h1C0);
        check("h4 m0_hready", 32'(a_m0_hready), 32'h1);
        check("h4 m0_hrdata", a_m0_hrdata, 32'h1B0);
        @(posedge hclk); #1;

        drive('{1, 1, 0, 0, 'h00, 0, 'h00, 0, SK, 0, 0, 0, SK, 0, 'h0});
        @(negedge hclk);
        check("h5 m1_hready", 32'(a_m1_hready), 32'h1);
        check("h5 m1_hrdata", a_m1_hrdata, 32'h1C4);
        @(posedge hclk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
